silife_scan_ext: RTL and testbench

Parametrised successor to the Silife LED-matrix row scanner. It multiplexes a ROWS x COLS cell matrix onto row and column drive lines, one row at a time.
- Per-row flow: drives `row_select` to the external cell memory, waits a programmable blanking gap (anti-ghosting, memory settle), then latches `cells` and lights the row for `cycles` clocks.
- Adds over the previous scanner: configurable geometry, blanking phase, run enable, frame-done pulse and optional brightness gating.
- Sits between the Silife cell grid and the display pins.

---
 rtl/silife_scan_ext.sv | 157 +++++++++++++++
 tb/tb_silife_scan_ext.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/silife_scan_ext.sv
// silife_scan_ext: row scanner for a ROWS x COLS LED matrix.
// For each row it addresses the external cell memory via row_select, blanks
// the matrix for blank_cycles+1 clocks, then latches cells and lights that
// row for max(cycles,1) clocks. frame_done pulses for one clock after the
// last row's DISPLAY phase.
//
// Optional feature macro: SILIFE_SCAN_BRIGHTNESS_EN adds a brightness input
// that limits how many DISPLAY clocks the columns are lit.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   enable       run scan; 0 = idle, outputs dark
//   invert       combinational XOR on rows/columns
//   cycles       DISPLAY dwell per row (0 treated as 1)
//   blank_cycles extra BLANK clocks per row
//   brightness   lit DISPLAY clocks (only with SILIFE_SCAN_BRIGHTNESS_EN)
//   cells        cell data for the addressed row
//   row_select   row address to the cell memory
//   rows         one-hot row drive (XOR invert)
//   columns      column drive (XOR invert)
//   frame_done   one-clock pulse at end of frame
module silife_scan_ext #(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int ROW_BITS     = $clog2(ROWS),
  parameter int CYCLES_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    invert,
  input  logic [CYCLES_WIDTH-1:0] cycles,
  input  logic [CYCLES_WIDTH-1:0] blank_cycles,
`ifdef SILIFE_SCAN_BRIGHTNESS_EN
  input  logic [CYCLES_WIDTH-1:0] brightness,
`endif
  input  logic [COLS-1:0]         cells,
  output logic [ROW_BITS-1:0]     row_select,
  output logic [ROWS-1:0]         rows,
  output logic [COLS-1:0]         columns,
  output logic                    frame_done
);

  typedef enum logic [1:0] {IDLE, BLANK, DISPLAY} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [CYCLES_WIDTH-1:0] counter;
  logic [ROWS-1:0]         row_raw;
  logic [COLS-1:0]         col_raw;
  logic                    phase_done;
  logic                    row_last;
  logic [CYCLES_WIDTH-1:0] display_len;
`ifdef SILIFE_SCAN_BRIGHTNESS_EN
  logic [CYCLES_WIDTH-1:0] bright_left;
`endif

  // Counter runs down to zero; zero marks the final clock of a phase.
  assign phase_done  = (counter == '0);
  assign row_last    = (row_select == ROW_BITS'(ROWS - 1));
  assign display_len = (cycles == '0) ? '0 : cycles - CYCLES_WIDTH'(1);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = BLANK;
        BLANK:   if (phase_done) state_next = DISPLAY;
        DISPLAY: if (phase_done) state_next = BLANK;
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath: counter, row address, latched row/column data, frame pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter    <= '0;
      row_select <= '0;
      row_raw    <= '0;
      col_raw    <= '0;
      frame_done <= 1'b0;
`ifdef SILIFE_SCAN_BRIGHTNESS_EN
      bright_left <= '0;
`endif
    end else if (!enable) begin
      counter    <= '0;
      row_select <= '0;
      row_raw    <= '0;
      col_raw    <= '0;
      frame_done <= 1'b0;
`ifdef SILIFE_SCAN_BRIGHTNESS_EN
      bright_left <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          counter    <= blank_cycles;
          row_select <= '0;
          row_raw    <= '0;
          col_raw    <= '0;
        end
        BLANK: begin
          if (phase_done) begin
            counter <= display_len;
            row_raw <= ROWS'(1) << row_select;
`ifdef SILIFE_SCAN_BRIGHTNESS_EN
            col_raw     <= (brightness == '0) ? '0 : cells;
            bright_left <= brightness;
`else
            col_raw <= cells;
`endif
          end else begin
            counter <= counter - CYCLES_WIDTH'(1);
          end
        end
        DISPLAY: begin
          if (phase_done) begin
            counter    <= blank_cycles;
            row_raw    <= '0;
            col_raw    <= '0;
            row_select <= row_last ? '0 : row_select + ROW_BITS'(1);
            frame_done <= row_last;
          end else begin
            counter <= counter - CYCLES_WIDTH'(1);
`ifdef SILIFE_SCAN_BRIGHTNESS_EN
            // bright_left counts lit clocks still owed, including the current one.
            if (bright_left <= CYCLES_WIDTH'(1)) col_raw <= '0;
            if (bright_left != '0) bright_left <= bright_left - CYCLES_WIDTH'(1);
`endif
          end
        end
        default: begin
          counter <= '0;
        end
      endcase
    end
  end

  // Output polarity
  always_comb begin
    rows    = row_raw ^ {ROWS{invert}};
    columns = col_raw ^ {COLS{invert}};
  end

endmodule

// File: tb/tb_silife_scan_ext.sv
module tb_silife_scan_ext;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        invert;
  logic [15:0] cycles;
  logic [15:0] blank_cycles;
`ifdef SILIFE_SCAN_BRIGHTNESS_EN
  logic [15:0] brightness;
`endif
  logic [7:0]  cells;
  logic [2:0]  row_select;
  logic [7:0]  rows;
  logic [7:0]  columns;
  logic        frame_done;

  logic [7:0]  cell_mem [8];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] rs;
    logic [7:0] rw;
    logic [7:0] cl;
    logic       fd;
  } exp_t;
  exp_t q[$];

  // Reference model state: phase 0 idle, 1 blank, 2 display; m_pos is the
  // clock index within the current row period.
  int         m_ph, m_row, m_pos, m_blen, m_dlen, m_bright;
  logic [7:0] m_lat;
  logic       m_fd;

  silife_scan_ext #(
    .ROWS(8), .COLS(8), .ROW_BITS(3), .CYCLES_WIDTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .invert(invert),
    .cycles(cycles),
    .blank_cycles(blank_cycles),
`ifdef SILIFE_SCAN_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .cells(cells),
    .row_select(row_select),
    .rows(rows),
    .columns(columns),
    .frame_done(frame_done)
  );

  assign cells = cell_mem[row_select];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    failures++;
    $error("FAIL %s timeout", tag);
  endtask

  task automatic model_reset();
    m_ph = 0; m_row = 0; m_pos = 0; m_fd = 1'b0; m_lat = '0;
  endtask

  task automatic model_step();
    if (!reset || !enable) begin
      model_reset();
    end else begin
      m_fd = 1'b0;
      case (m_ph)
        0: begin
          m_ph = 1; m_pos = 0; m_blen = int'(blank_cycles) + 1;
        end
        1: begin
          if (m_pos == m_blen - 1) begin
            m_ph   = 2;
            m_dlen = (cycles == 0) ? 1 : int'(cycles);
            m_lat  = cell_mem[m_row];
`ifdef SILIFE_SCAN_BRIGHTNESS_EN
            m_bright = int'(brightness);
`else
            m_bright = 1 << 30;
`endif
          end
          m_pos++;
        end
        default: begin
          if (m_pos == m_blen + m_dlen - 1) begin
            m_ph  = 1;
            m_fd  = (m_row == 7);
            m_row = (m_row + 1) % 8;
            m_pos = 0;
            m_blen = int'(blank_cycles) + 1;
          end else begin
            m_pos++;
          end
        end
      endcase
    end
  endtask

  // One clock: model predicts, expectation queued, DUT sampled 1 ns after edge.
  task automatic tick();
    exp_t e;
    model_step();
    e.rs = 3'(m_row);
    e.rw = (m_ph == 2) ? 8'(1 << m_row) : 8'h00;
    e.cl = (m_ph == 2 && (m_pos - m_blen) < m_bright) ? m_lat : 8'h00;
    e.fd = m_fd;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("row_select", 32'(row_select), 32'(e.rs));
    chk("rows",       32'(rows),       32'(e.rw ^ {8{invert}}));
    chk("columns",    32'(columns),    32'(e.cl ^ {8{invert}}));
    chk("frame_done", 32'(frame_done), 32'(e.fd));
  endtask

  task automatic wait_disp(input int r);
    int n = 0;
    while (!(m_ph == 2 && m_row == r) && n < 300) begin
      tick();
      n++;
    end
    if (!(m_ph == 2 && m_row == r)) timeout($sformatf("wait_disp_row%0d", r));
  endtask

  // Ticks until the DUT pulses frame_done; n returns the number of clocks taken.
  task automatic ticks_to_fd(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (frame_done !== 1'b1 && n < 300);
    if (frame_done !== 1'b1) timeout("frame_done_wait");
  endtask

  initial begin
    int n;
    int rs_max;
    cell_mem[0] = 8'h20; cell_mem[1] = 8'h01; cell_mem[2] = 8'h02; cell_mem[3] = 8'h03;
    cell_mem[4] = 8'h24; cell_mem[5] = 8'h05; cell_mem[6] = 8'h66; cell_mem[7] = 8'hAA;
    reset = 1'b0; enable = 1'b0; invert = 1'b0;
    cycles = 16'd3; blank_cycles = 16'd1;
`ifdef SILIFE_SCAN_BRIGHTNESS_EN
    brightness = 16'hFFFF;
`endif
    model_reset();
    m_blen = 1; m_dlen = 1; m_bright = 1 << 30;

    // Reset state
    repeat (3) tick();
    chk("reset_rows", 32'(rows), 32'h00);
    chk("reset_cols", 32'(columns), 32'h00);
    chk("reset_rs", 32'(row_select), 32'h0);
    chk("reset_fd", 32'(frame_done), 32'h0);

    // Basic scan
    reset = 1'b1; enable = 1'b1;
    tick();
    chk("blank_rows", 32'(rows), 32'h00);
    chk("blank_cols", 32'(columns), 32'h00);
    wait_disp(0);
    chk("row0_rows", 32'(rows), 32'h01);
    chk("row0_cols", 32'(columns), 32'h20);
    wait_disp(4);
    chk("row4_rows", 32'(rows), 32'h10);
    chk("row4_cols", 32'(columns), 32'h24);
    wait_disp(7);
    chk("row7_rows", 32'(rows), 32'h80);
    chk("row7_cols", 32'(columns), 32'hAA);
    ticks_to_fd(n);
    ticks_to_fd(n);
    chk("frame_period_40", 32'(n), 32'd40);

    // Invert mid-frame
    wait_disp(2);
    tick();
    invert = 1'b1;
    #1;
    chk("inv_now_rows", 32'(rows), 32'hFB);
    chk("inv_now_cols", 32'(columns), 32'hFD);
    n = 0;
    while (m_ph != 1 && n < 20) begin tick(); n++; end
    chk("inv_blank_rows", 32'(rows), 32'hFF);
    chk("inv_blank_cols", 32'(columns), 32'hFF);
    wait_disp(6);
    chk("inv_row6_rows", 32'(rows), 32'hBF);
    chk("inv_row6_cols", 32'(columns), 32'h99);
    ticks_to_fd(n);
    ticks_to_fd(n);
    chk("inv_frame_period", 32'(n), 32'd40);
    invert = 1'b0;

    // Minimum timing
    cycles = 16'd0; blank_cycles = 16'd0;
    ticks_to_fd(n);
    ticks_to_fd(n);
    chk("frame_period_16", 32'(n), 32'd16);
    rs_max = 0;
    repeat (20) begin
      tick();
      if (int'(row_select) > rs_max) rs_max = int'(row_select);
    end
    chk("rs_max", 32'(rs_max), 32'd7);
    cycles = 16'd3; blank_cycles = 16'd1;

    // Asynchronous reset during row 5 DISPLAY
    wait_disp(5);
    tick();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("areset_rows", 32'(rows), 32'h00);
    chk("areset_cols", 32'(columns), 32'h00);
    chk("areset_rs", 32'(row_select), 32'h0);
    chk("areset_fd", 32'(frame_done), 32'h0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk("restart_rs", 32'(row_select), 32'h0);
    chk("restart_rows", 32'(rows), 32'h00);
    n = 0;
    while (rows == 8'h00 && n < 20) begin tick(); n++; end
    chk("restart_row0_rows", 32'(rows), 32'h01);
    chk("restart_row0_cols", 32'(columns), 32'h20);

    // enable dropped during row 3
    wait_disp(3);
    enable = 1'b0;
    repeat (10) tick();
    chk("idle_rows", 32'(rows), 32'h00);
    chk("idle_cols", 32'(columns), 32'h00);
    chk("idle_rs", 32'(row_select), 32'h0);
    chk("idle_fd", 32'(frame_done), 32'h0);
    enable = 1'b1;
    n = 0;
    do begin tick(); n++; end while (rows == 8'h00 && n < 20);
    chk("resume_rs", 32'(row_select), 32'h0);
    chk("resume_rows", 32'(rows), 32'h01);

`ifdef SILIFE_SCAN_BRIGHTNESS_EN
    // Brightness gating
    cycles = 16'd4; brightness = 16'd1;
    wait_disp(0);
    wait_disp(7);
    chk("br_clk1_cols", 32'(columns), 32'hAA);
    chk("br_clk1_rows", 32'(rows), 32'h80);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk($sformatf("br_clk%0d_cols", i), 32'(columns), 32'h00);
      chk($sformatf("br_clk%0d_rows", i), 32'(rows), 32'h80);
    end
`endif

    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
